// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-seg scan controller driving one shared hex decoder.
// Define SEG7_LZB_EN to blank leading-zero digits.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic                    load_ack,
    output logic [3:0]              dec_in,
    input  logic [6:0]              dec_out,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en_n,
    output logic                    frame_done
);
    localparam int DW   = 4 * NUM_DIGITS;
    localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(NUM_DIGITS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] DWELL = 2'd2;

    localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DW-1:0] active;
    logic [DW-1:0] pending;
    logic          pend_flag;

    logic [IW-1:0] idx_nx;
    logic [3:0]    nxt_nib;
    logic [6:0]    dwell_seg;

    always_comb begin
        idx_nx  = idx + IW'(1);
        nxt_nib = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_nx == IW'(k)) nxt_nib = active[4*k +: 4];
        end
    end

`ifdef SEG7_LZB_EN
    logic lz;

    // Digit k>0 is a leading zero when it and every higher nibble are zero.
    always_comb begin
        lz = 1'b0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) lz = ((active >> (4*k)) == '0);
        end
        dwell_seg = lz ? 7'h7F : dec_out;
    end
`else
    always_comb begin
        dwell_seg = dec_out;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            pending    <= '0;
            pend_flag  <= 1'b0;
            seg        <= 7'h7F;
            dig_en_n   <= '1;
            dec_in     <= 4'h0;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
            if (load) begin
                pending   <= value;
                pend_flag <= 1'b1;
            end
            if (!enable) begin
                state    <= IDLE;
                cnt      <= '0;
                idx      <= '0;
                seg      <= 7'h7F;
                dig_en_n <= '1;
                dec_in   <= 4'h0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= BLANK;
                        cnt      <= '0;
                        idx      <= '0;
                        seg      <= 7'h7F;
                        dig_en_n <= '1;
                        dec_in   <= active[3:0];
                    end
                    BLANK: begin
                        if (cnt == B_LAST) begin
                            state    <= DWELL;
                            cnt      <= '0;
                            seg      <= dwell_seg;
                            dig_en_n <= ~(ONE << idx);
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DWELL: begin
                        seg <= dwell_seg;
                        if (cnt == D_LAST) begin
                            state    <= BLANK;
                            cnt      <= '0;
                            seg      <= 7'h7F;
                            dig_en_n <= '1;
                            if (idx == I_LAST) begin
                                idx        <= '0;
                                frame_done <= 1'b1;
                                // New frame starts from the value applied here.
                                if (pend_flag) begin
                                    active    <= pending;
                                    pend_flag <= load;
                                    load_ack  <= 1'b1;
                                    dec_in    <= pending[3:0];
                                end else begin
                                    dec_in <= active[3:0];
                                end
                            end else begin
                                idx    <= idx_nx;
                                dec_in <= nxt_nib;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
